// File: rtl/jtag_program_loader_pkg.sv
// Shared constants, instruction encodings and decode helper for the JTAG program loader.
package jtag_program_loader_pkg;

    localparam int unsigned IR_W = 4;
    localparam int unsigned DR_W = 32;

    localparam logic [IR_W-1:0] IR_LOAD_PROGRAM = 4'b0001;
    localparam logic [IR_W-1:0] IR_SCAN_TEST    = 4'b0010;
    localparam logic [IR_W-1:0] IR_BYPASS       = 4'b0011;
    // Fixed pattern loaded into the IR chain on CAPTURE_IR
    localparam logic [IR_W-1:0] IR_CAPTURE      = 4'b0001;

    typedef enum logic [1:0] {
        InstrBypass,
        InstrLoadProgram,
        InstrScanTest
    } tap_instr_e;

    // Unknown opcodes fall back to bypass behaviour
    function automatic tap_instr_e decode_ir(input logic [IR_W-1:0] ir);
        case (ir)
            IR_LOAD_PROGRAM: return InstrLoadProgram;
            IR_SCAN_TEST:    return InstrScanTest;
            default:         return InstrBypass;
        endcase
    endfunction

endpackage

// File: rtl/jtag_program_loader_if.sv
// Instruction memory write port driven by the JTAG program loader.
interface jtag_program_loader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DR_W   = 32
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DR_W-1:0]   wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/jtag_program_loader_shift_reg.sv
// Capture/shift/update register: serial chain plus a parallel register loaded on update.
module jtag_program_loader_shift_reg #(
    parameter int unsigned  W      = 4,
    parameter logic [W-1:0] PAR_RST = '0
) (
    input  logic         tck_i,
    input  logic         rst_i,
    input  logic         capture_i,
    input  logic         shift_i,
    input  logic         update_i,
    input  logic         tdi_i,
    input  logic [W-1:0] cap_data_i,
    output logic [W-1:0] sr_o,
    output logic [W-1:0] par_o
);

    logic [W-1:0] sr_q, sr_d;
    logic [W-1:0] par_q, par_d;

    // Next state with strobe priority capture > shift > update
    always_comb begin
        sr_d  = sr_q;
        par_d = par_q;
        if (capture_i) begin
            sr_d = cap_data_i;
        end else if (shift_i) begin
            sr_d = {tdi_i, sr_q[W-1:1]};
        end else if (update_i) begin
            par_d = sr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            par_q <= PAR_RST;
        end else begin
            sr_q  <= sr_d;
            par_q <= par_d;
        end
    end

    assign sr_o  = sr_q;
    assign par_o = par_q;

endmodule

// File: rtl/jtag_program_loader.sv
// JTAG IR/DR chains: loads program words into instruction memory, scans out core status,
// and provides the bypass bit.
module jtag_program_loader
    import jtag_program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                  tck_i,
    input  logic                  rst_i,
    input  logic                  tdi_i,
    input  logic                  captureIR_i,
    input  logic                  shiftIR_i,
    input  logic                  updateIR_i,
    input  logic                  captureDR_i,
    input  logic                  shiftDR_i,
    input  logic                  updateDR_i,
    input  logic                  selectIR_i,
    input  logic                  enable_i,
    input  logic [DR_W-1:0]       scan_data_i,
    output logic                  tdo_o,
    output logic [IR_W-1:0]       ir_o,
    output logic                  cpu_halt_o,
    jtag_program_loader_if.master imem_o
);

    logic [IR_W-1:0]   ir_sr;
    logic [IR_W-1:0]   ir_q;
    logic [DR_W-1:0]   dr_sr;
    logic [DR_W-1:0]   wdata_q;
    logic [DR_W-1:0]   dr_cap_data;
    tap_instr_e        instr;
    logic              dr_active;
    logic              dr_capture;
    logic              dr_shift;
    logic              dr_write;
    logic              ir_update;

    logic              byp_q, byp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;

    assign instr      = decode_ir(ir_q);
    assign dr_active  = (instr != InstrBypass);
    assign dr_capture = captureDR_i && dr_active;
    assign dr_shift   = shiftDR_i && dr_active;
    assign dr_write   = updateDR_i && !captureDR_i && !shiftDR_i && (instr == InstrLoadProgram);
    assign ir_update  = updateIR_i && !captureIR_i && !shiftIR_i;

    // Program mode captures the next write address so the host can read it back
    assign dr_cap_data = (instr == InstrLoadProgram) ? DR_W'(addr_q) : scan_data_i;

    jtag_program_loader_shift_reg #(
        .W       (IR_W),
        .PAR_RST (IR_BYPASS)
    ) u_ir (
        .tck_i      (tck_i),
        .rst_i      (rst_i),
        .capture_i  (captureIR_i),
        .shift_i    (shiftIR_i),
        .update_i   (updateIR_i),
        .tdi_i      (tdi_i),
        .cap_data_i (IR_CAPTURE),
        .sr_o       (ir_sr),
        .par_o      (ir_q)
    );

    // The DR parallel register doubles as the held write-data output
    jtag_program_loader_shift_reg #(
        .W       (DR_W),
        .PAR_RST ('0)
    ) u_dr (
        .tck_i      (tck_i),
        .rst_i      (rst_i),
        .capture_i  (dr_capture),
        .shift_i    (dr_shift),
        .update_i   (dr_write),
        .tdi_i      (tdi_i),
        .cap_data_i (dr_cap_data),
        .sr_o       (dr_sr),
        .par_o      (wdata_q)
    );

    // Bypass bit: cleared on capture, follows TDI on shift
    always_comb begin
        byp_d = byp_q;
        if (!dr_active) begin
            if (captureDR_i) begin
                byp_d = 1'b0;
            end else if (shiftDR_i) begin
                byp_d = tdi_i;
            end
        end
    end

    // Address counter and one-cycle write strobe
    always_comb begin
        addr_d  = addr_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        if (ir_update && (ir_sr == IR_LOAD_PROGRAM)) begin
            addr_d = '0;
        end else if (dr_write) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
        end
    end

    // Loader state registers with synchronous reset
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            byp_q   <= 1'b0;
            addr_q  <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
        end else begin
            byp_q   <= byp_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
        end
    end

    // Serial output mux
    always_comb begin
        tdo_o = 1'b0;
        if (enable_i) begin
            if (selectIR_i) begin
                tdo_o = ir_sr[0];
            end else if (dr_active) begin
                tdo_o = dr_sr[0];
            end else begin
                tdo_o = byp_q;
            end
        end
    end

    assign ir_o         = ir_q;
    assign cpu_halt_o   = (ir_q == IR_LOAD_PROGRAM);
    assign imem_o.we    = we_q;
    assign imem_o.addr  = waddr_q;
    assign imem_o.wdata = wdata_q;

endmodule

// File: tb/tb_jtag_program_loader.sv
// Directed bench: two loaders (12-bit and 4-bit address) share stimulus; writes are
// scoreboarded against queues filled when the update strobe is driven.
module tb_jtag_program_loader;
    import jtag_program_loader_pkg::*;

    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_CIR  = 6'b100000;
    localparam logic [5:0] S_SIR  = 6'b010000;
    localparam logic [5:0] S_UIR  = 6'b001000;
    localparam logic [5:0] S_CDR  = 6'b000100;
    localparam logic [5:0] S_SDR  = 6'b000010;
    localparam logic [5:0] S_UDR  = 6'b000001;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        tck = 1'b0;
    logic        rst, tdi, cir, sir, uir, cdr, sdr, udr, sel, en;
    logic [31:0] scan;
    logic        tdo_m, tdo_s, halt_m, halt_s;
    logic [3:0]  ir_m, ir_s;

    wr_t         exp_m[$];
    wr_t         exp_s[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] m_addr;
    logic [3:0]  s_addr;
    logic [3:0]  cur_ir;
    logic [3:0]  ir_bits;
    logic [31:0] dout;
    logic [31:0] din;
    logic [7:0]  exp8;

    always #5 tck = ~tck;

    jtag_program_loader_if #(.ADDR_W(12), .DR_W(32)) imem_m ();
    jtag_program_loader_if #(.ADDR_W(4),  .DR_W(32)) imem_s ();

    jtag_program_loader #(.ADDR_W(12), .ADDR_STEP(4)) dut (
        .tck_i(tck), .rst_i(rst), .tdi_i(tdi),
        .captureIR_i(cir), .shiftIR_i(sir), .updateIR_i(uir),
        .captureDR_i(cdr), .shiftDR_i(sdr), .updateDR_i(udr),
        .selectIR_i(sel), .enable_i(en), .scan_data_i(scan),
        .tdo_o(tdo_m), .ir_o(ir_m), .cpu_halt_o(halt_m), .imem_o(imem_m)
    );

    jtag_program_loader #(.ADDR_W(4), .ADDR_STEP(4)) dut_small (
        .tck_i(tck), .rst_i(rst), .tdi_i(tdi),
        .captureIR_i(cir), .shiftIR_i(sir), .updateIR_i(uir),
        .captureDR_i(cdr), .shiftDR_i(sdr), .updateDR_i(udr),
        .selectIR_i(sel), .enable_i(en), .scan_data_i(scan),
        .tdo_o(tdo_s), .ir_o(ir_s), .cpu_halt_o(halt_s), .imem_o(imem_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and scoreboard any write strobe seen after the edge
    task automatic tick();
        wr_t w;
        @(posedge tck);
        #1;
        if (imem_m.we === 1'b1) begin
            if (exp_m.size() == 0) begin
                check("m_unexpected_write", 64'(imem_m.we), 64'd0);
            end else begin
                w = exp_m.pop_front();
                check("m_wr_addr", 64'(imem_m.addr), 64'(w.addr));
                check("m_wr_data", 64'(imem_m.wdata), 64'(w.data));
            end
        end
        if (imem_s.we === 1'b1) begin
            if (exp_s.size() == 0) begin
                check("s_unexpected_write", 64'(imem_s.we), 64'd0);
            end else begin
                w = exp_s.pop_front();
                check("s_wr_addr", 64'(imem_s.addr), 64'(w.addr));
                check("s_wr_data", 64'(imem_s.wdata), 64'(w.data));
            end
        end
    endtask

    task automatic drive(input logic [5:0] s, input logic d);
        {cir, sir, uir, cdr, sdr, udr} = s;
        tdi = d;
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
        sel = 1'b1;
        drive(S_CIR, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(S_SIR, op[i]);
            #1;
            tdo_bits[i] = tdo_m;
            tick();
        end
        drive(S_UIR, 1'b0);
        tick();
        drive(S_IDLE, 1'b0);
        sel = 1'b0;
        tick();
        cur_ir = op;
        if (op == IR_LOAD_PROGRAM) begin
            m_addr = '0;
            s_addr = '0;
        end
    endtask

    task automatic shift_dr(input logic [31:0] d, input int n, input bit upd,
                            output logic [31:0] out);
        logic [31:0] srm, srs;
        sel = 1'b0;
        out = '0;
        if (cur_ir == IR_LOAD_PROGRAM) begin
            srm = 32'(m_addr);
            srs = 32'(s_addr);
        end else if (cur_ir == IR_SCAN_TEST) begin
            srm = scan;
            srs = scan;
        end else begin
            srm = '0;
            srs = '0;
        end
        drive(S_CDR, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            drive(S_SDR, d[i]);
            #1;
            out[i] = tdo_m;
            srm = {d[i], srm[31:1]};
            srs = {d[i], srs[31:1]};
            tick();
        end
        if (upd) begin
            if (cur_ir == IR_LOAD_PROGRAM) begin
                exp_m.push_back('{addr: m_addr, data: srm});
                exp_s.push_back('{addr: 12'(s_addr), data: srs});
                m_addr = m_addr + 12'd4;
                s_addr = s_addr + 4'd4;
            end
            drive(S_UDR, 1'b0);
            tick();
        end
        drive(S_IDLE, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; en = 1'b1; scan = '0;
        drive(S_IDLE, 1'b0);
        m_addr = '0; s_addr = '0; cur_ir = IR_BYPASS;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ir", 64'(ir_m), 64'(4'b0011));
        check("rst_halt", 64'(halt_m), 64'd0);
        check("rst_we", 64'(imem_m.we), 64'd0);
        check("rst_tdo", 64'(tdo_m), 64'd0);
        check("rst_addr", 64'(imem_m.addr), 64'd0);

        // IR load of LOAD_PROGRAM
        load_ir(4'b0001, ir_bits);
        check("ir_load", 64'(ir_m), 64'(4'b0001));
        check("ir_halt", 64'(halt_m), 64'd1);
        check("ir_tdo_bit0", 64'(ir_bits[0]), 64'd1);
        check("ir_tdo_bit1", 64'(ir_bits[1]), 64'd0);
        sel = 1'b1;
        #1;
        check("tdo_ir_path", 64'(tdo_m), 64'd1);
        en = 1'b0;
        #1;
        check("tdo_disabled", 64'(tdo_m), 64'd0);
        en = 1'b1;
        sel = 1'b0;

        // Program two words, then read back next address
        shift_dr(32'h00500093, 32, 1'b1, dout);
        shift_dr(32'h00100113, 32, 1'b1, dout);
        check("prog_hold_addr", 64'(imem_m.addr), 64'h4);
        check("prog_hold_data", 64'(imem_m.wdata), 64'h00100113);
        check("prog_we_low", 64'(imem_m.we), 64'd0);
        shift_dr(32'h0, 32, 1'b0, dout);
        check("prog_readback", 64'(dout), 64'h8);
        check("prog_halt", 64'(halt_m), 64'd1);

        // Bypass: stream comes back delayed by one cycle
        load_ir(4'b0011, ir_bits);
        check("byp_ir", 64'(ir_m), 64'(4'b0011));
        check("byp_halt", 64'(halt_m), 64'd0);
        din = 32'h0000004D;
        shift_dr(din, 8, 1'b0, dout);
        exp8 = {din[6:0], 1'b0};
        check("byp_stream", 64'(dout[7:0]), 64'(exp8));

        // Scan test
        load_ir(4'b0010, ir_bits);
        scan = 32'hDEADBEEF;
        shift_dr(32'h0, 32, 1'b1, dout);
        check("scan_out", 64'(dout), 64'hDEADBEEF);
        check("scan_ir", 64'(ir_m), 64'(4'b0010));
        check("scan_halt", 64'(halt_m), 64'd0);

        // Unknown opcode behaves as bypass
        load_ir(4'b1010, ir_bits);
        check("unk_halt", 64'(halt_m), 64'd0);
        din = 32'h00000005;
        shift_dr(din, 4, 1'b1, dout);
        check("unk_bypass", 64'(dout[3:0]), 64'({din[2:0], 1'b0}));

        // Address wrap on the narrow instance
        load_ir(4'b0001, ir_bits);
        for (int k = 0; k < 5; k++) begin
            shift_dr($urandom, 32, 1'b1, dout);
        end
        check("wrap_s_addr", 64'(imem_s.addr), 64'h0);
        check("wrap_m_addr", 64'(imem_m.addr), 64'h10);

        // Reset mid-shift discards the partial word, even with update asserted
        drive(S_CDR, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(S_SDR, 1'($urandom));
            tick();
        end
        drive(S_UDR, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(S_IDLE, 1'b0);
        m_addr = '0; s_addr = '0; cur_ir = IR_BYPASS;
        #1;
        check("mrst_ir", 64'(ir_m), 64'(4'b0011));
        check("mrst_ir_s", 64'(ir_s), 64'(4'b0011));
        check("mrst_halt", 64'(halt_m), 64'd0);
        check("mrst_addr", 64'(imem_m.addr), 64'd0);
        check("mrst_addr_s", 64'(imem_s.addr), 64'd0);
        check("mrst_wdata", 64'(imem_m.wdata), 64'd0);
        check("mrst_we", 64'(imem_m.we), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end

        // After reset the counter restarts from zero
        load_ir(4'b0001, ir_bits);
        shift_dr(32'h0, 32, 1'b0, dout);
        check("mrst_readback", 64'(dout), 64'h0);
        tick();
        check("m_pending", 64'(exp_m.size()), 64'd0);
        check("s_pending", 64'(exp_s.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
